counter_rate_sequencer: RTL and testbench
=========================================

Name: counter_rate_sequencer

Overview:
- Periodically snapshots NUM_CH free-running counters, all synchronized into the clk domain upstream.
- Computes each channel's increment over a programmable gate window.
- Streams the per-channel deltas out one channel per beat over a valid/ready interface.
- Sits between the bank of clock-domain-crossing counters and the readout/event-builder FIFO. It is the block that schedules when counters are sampled and in what order results leave.

Parameters:
- NUM_CH, 4, number of counter channels (2..16).
- SZ_WIDTH, 32, width of each counter and of each delta.
- CH_W, 4, width of out_ch; must satisfy 2^CH_W >= NUM_CH.
- SEQ_W, 16, width of the window sequence number.

Ports:
- clk  in  1  single clock; all logic is synchronous to its rising edge.
- rst  in  1  synchronous reset, active-low (0 = reset), sampled on the clk rising edge.
- enable  in  1  run control; level-sensitive.
- gate_cycles  in  32  window length in clk cycles; sampled at each window start.
- cnt_in  in  NUM_CH*SZ_WIDTH  synchronized counter values; channel k is at bits [k*SZ_WIDTH +: SZ_WIDTH].
- out_valid  out  1  result beat valid.
- out_ready  in  1  downstream accept.
- out_ch  out  CH_W  channel index of the current beat.
- out_delta  out  SZ_WIDTH  counter increment over the window.
- out_seq  out  SEQ_W  window sequence number.
- out_last  out  1  asserted with the beat for channel NUM_CH-1.
- busy  out  1  high whenever the FSM is not in IDLE.
- overrun  out  1  sticky; a window expired while a drain was still in progress.

Behaviour:
- Reset (rst=0): FSM goes to IDLE. All outputs are 0. Timer, base registers, snap registers and sequence counter are cleared. Reset overrides every other input, including mid-drain.
- FSM states: IDLE, PRIME, WAIT, DRAIN.
- IDLE:
  - When enable=1: base[k] <= cnt_in[k] for all k.
  - Load timer with G-1, where G = max(gate_cycles, NUM_CH+1). Go to PRIME.
- PRIME: lasts one cycle. No output is produced. Go to WAIT.
- Timer behaviour:
  - Decrements every cycle outside IDLE.
  - Expiry is the cycle where timer==0. On expiry it reloads G-1 from the current gate_cycles.
  - Expiry occurs exactly G cycles after each load.
- Expiry in WAIT:
  - snap[k] <= cnt_in[k] for all k, all channels on the same edge.
  - Go to DRAIN with channel index 0.
  - out_valid rises on the cycle after expiry. Latency from expiry to the first beat is 1 cycle.
- DRAIN:
  - out_delta = snap[ch] - base[ch] modulo 2^SZ_WIDTH, so counter wrap-around is handled transparently.
  - A beat transfers on out_valid & out_ready. While out_ready=0, out_ch, out_delta, out_seq and out_last are held stable.
  - On each transfer, base[ch] <= snap[ch] and ch increments.
  - Transfer of channel NUM_CH-1: out_seq increments (wraps at 2^SEQ_W). Go to WAIT.
  - Minimum drain time is NUM_CH cycles.
- Expiry during DRAIN:
  - overrun <= 1 (sticky until reset).
  - No new snapshot is taken and the timer reloads normally.
  - Base registers are not advanced for the missed window, so the next delta spans all elapsed windows. out_seq still increments only once per emitted window.
- enable=0:
  - In PRIME or WAIT: go to IDLE on the next cycle.
  - In DRAIN: a beat already presented stays until accepted, then go to IDLE; the remaining channels are discarded and out_seq is not incremented.
  - overrun is retained.
- Simultaneous expiry and final-channel transfer in DRAIN: the transfer completes and the state enters WAIT. The expiry counts as overrun, with no snapshot.
- busy = (state != IDLE).

Optional Feature:
- Macro: COUNTER_RATE_SEQUENCER_WINDOW_LEN_EN.
- Defined:
  - Adds output port out_cycles (32 bits), presented with every beat: the number of clk cycles between the snapshot that set base[ch] and the current snap.
  - A cycle counter is captured at each snapshot; per-channel base timestamps advance with base[ch].
  - Normally out_cycles equals G; after an overrun it equals the merged span.
- Undefined: the port and its registers are absent; behaviour is otherwise identical.

Test Plan (NUM_CH=4, SZ_WIDTH=32):
- Nominal: gate_cycles=100, out_ready=1; ch0 +1/cycle, ch1 +3/cycle, ch2 and ch3 static -> each window emits deltas 100, 300, 0, 0 on ch0..3; out_last on ch3; out_seq 0, 1, 2.
- Wrap: ch2 base 0xFFFFFFF0, +1 every 2 cycles, gate_cycles=64 -> ch2 delta 32 (0x20), with no discontinuity across the wrap.
- Backpressure overrun: gate_cycles=100, out_ready=0 for 150 cycles from the first beat -> overrun=1 stays set; next window's ch0 delta=200 (out_cycles=200 with the macro); out_seq advances by 1.
- Clamp: gate_cycles=2 -> effective window of 5 cycles; with out_ready=1, no overrun over 50 windows.
- Reset mid-drain: rst=0 while beat ch1 is valid -> next cycle out_valid=0, out_seq=0, overrun=0, busy=0; after release with enable=1, PRIME re-baselines, so the first window's deltas exclude pre-reset counts.
- Disable mid-drain: enable=0 during the ch1 beat with out_ready=0 -> beat held; after acceptance busy=0, ch2/ch3 not emitted, out_seq unchanged.

Source files
------------

// File: rtl/counter_rate_sequencer.sv
// Snapshots NUM_CH counters once per gate window and streams per-channel deltas over valid/ready.
// Define COUNTER_RATE_SEQUENCER_WINDOW_LEN_EN to add out_cycles (clk cycles spanned by each delta).
module counter_rate_sequencer #(
    parameter int NUM_CH   = 4,
    parameter int SZ_WIDTH = 32,
    parameter int CH_W     = 4,
    parameter int SEQ_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [31:0]                gate_cycles,
    input  logic [NUM_CH*SZ_WIDTH-1:0] cnt_in,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [CH_W-1:0]            out_ch,
    output logic [SZ_WIDTH-1:0]        out_delta,
    output logic [SEQ_W-1:0]           out_seq,
    output logic                       out_last,
`ifdef COUNTER_RATE_SEQUENCER_WINDOW_LEN_EN
    output logic [31:0]                out_cycles,
`endif
    output logic                       busy,
    output logic                       overrun
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_PRIME = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    localparam logic [31:0]     MIN_GATE = 32'(NUM_CH + 1);
    localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

    state_t                             state_q, state_d;
    logic [31:0]                        timer_q, timer_d;
    logic [CH_W-1:0]                    ch_q, ch_d;
    logic [SEQ_W-1:0]                   seq_q, seq_d;
    logic                               overrun_q, overrun_d;
    logic [SZ_WIDTH-1:0]                delta_q, delta_d;
    logic [NUM_CH-1:0][SZ_WIDTH-1:0]    base_q, base_d;
    logic [NUM_CH-1:0][SZ_WIDTH-1:0]    snap_q, snap_d;
    logic [31:0]                        reload_s;
    logic                               expire_s;
    logic                               xfer_s;
    logic [CH_W-1:0]                    ch_next_s;
    logic [SZ_WIDTH-1:0]                nxt_delta_s;
`ifdef COUNTER_RATE_SEQUENCER_WINDOW_LEN_EN
    logic [31:0]                        cyc_q;
    logic [31:0]                        snap_ts_q, snap_ts_d;
    logic [31:0]                        cycles_q, cycles_d;
    logic [NUM_CH-1:0][31:0]            base_ts_q, base_ts_d;
    logic [31:0]                        nxt_cycles_s;
`endif

    function automatic logic [SZ_WIDTH-1:0] chan(input logic [NUM_CH*SZ_WIDTH-1:0] bus, input int k);
        return bus[k*SZ_WIDTH +: SZ_WIDTH];
    endfunction

    // Short gate values are clamped so a full drain always fits inside one window.
    assign reload_s  = ((gate_cycles < MIN_GATE) ? MIN_GATE : gate_cycles) - 32'd1;
    assign expire_s  = (state_q != S_IDLE) && (timer_q == 32'd0);
    assign xfer_s    = (state_q == S_DRAIN) && out_ready;
    assign ch_next_s = ch_q + CH_W'(1);

    // Select the delta (and span) of the channel following the one being transferred
    always_comb begin
        nxt_delta_s = {SZ_WIDTH{1'b0}};
`ifdef COUNTER_RATE_SEQUENCER_WINDOW_LEN_EN
        nxt_cycles_s = 32'd0;
`endif
        for (int k = 0; k < NUM_CH; k++) begin
            nxt_delta_s = (CH_W'(k) == ch_next_s) ? (snap_q[k] - base_q[k]) : nxt_delta_s;
`ifdef COUNTER_RATE_SEQUENCER_WINDOW_LEN_EN
            nxt_cycles_s = (CH_W'(k) == ch_next_s) ? (snap_ts_q - base_ts_q[k]) : nxt_cycles_s;
`endif
        end
    end

    // Next-state logic for the sequencer FSM, timer and data registers
    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        ch_d      = ch_q;
        seq_d     = seq_q;
        overrun_d = overrun_q;
        delta_d   = delta_q;
        base_d    = base_q;
        snap_d    = snap_q;
`ifdef COUNTER_RATE_SEQUENCER_WINDOW_LEN_EN
        snap_ts_d = snap_ts_q;
        cycles_d  = cycles_q;
        base_ts_d = base_ts_q;
`endif
        if (state_q == S_IDLE) begin
            timer_d = timer_q;
        end else if (expire_s) begin
            timer_d = reload_s;
        end else begin
            timer_d = timer_q - 32'd1;
        end

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        base_d[k] = chan(cnt_in, k);
`ifdef COUNTER_RATE_SEQUENCER_WINDOW_LEN_EN
                        base_ts_d[k] = cyc_q;
`endif
                    end
                    timer_d = reload_s;
                    state_d = S_PRIME;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PRIME: begin
                state_d = enable ? S_WAIT : S_IDLE;
            end
            S_WAIT: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (expire_s) begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        snap_d[k] = chan(cnt_in, k);
                    end
                    delta_d = chan(cnt_in, 0) - base_q[0];
`ifdef COUNTER_RATE_SEQUENCER_WINDOW_LEN_EN
                    snap_ts_d = cyc_q;
                    cycles_d  = cyc_q - base_ts_q[0];
`endif
                    ch_d    = {CH_W{1'b0}};
                    state_d = S_DRAIN;
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_DRAIN: begin
                // A window that expires mid-drain is folded into the next one: no snapshot.
                overrun_d = expire_s ? 1'b1 : overrun_q;
                if (xfer_s) begin
                    for (int k = 0; k < NUM_CH; k++) begin
                        base_d[k] = (CH_W'(k) == ch_q) ? snap_q[k] : base_q[k];
`ifdef COUNTER_RATE_SEQUENCER_WINDOW_LEN_EN
                        base_ts_d[k] = (CH_W'(k) == ch_q) ? snap_ts_q : base_ts_q[k];
`endif
                    end
                    if (!enable) begin
                        state_d = S_IDLE;
                    end else if (ch_q == LAST_CH) begin
                        seq_d   = seq_q + SEQ_W'(1);
                        state_d = S_WAIT;
                    end else begin
                        ch_d    = ch_next_s;
                        delta_d = nxt_delta_s;
`ifdef COUNTER_RATE_SEQUENCER_WINDOW_LEN_EN
                        cycles_d = nxt_cycles_s;
`endif
                        state_d = S_DRAIN;
                    end
                end else begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            timer_q   <= 32'd0;
            ch_q      <= {CH_W{1'b0}};
            seq_q     <= {SEQ_W{1'b0}};
            overrun_q <= 1'b0;
            delta_q   <= {SZ_WIDTH{1'b0}};
            base_q    <= {(NUM_CH*SZ_WIDTH){1'b0}};
            snap_q    <= {(NUM_CH*SZ_WIDTH){1'b0}};
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            ch_q      <= ch_d;
            seq_q     <= seq_d;
            overrun_q <= overrun_d;
            delta_q   <= delta_d;
            base_q    <= base_d;
            snap_q    <= snap_d;
        end
    end

`ifdef COUNTER_RATE_SEQUENCER_WINDOW_LEN_EN
    // Free-running cycle stamp plus the per-channel timestamps that track base/snap
    always_ff @(posedge clk) begin
        if (!rst) begin
            cyc_q     <= 32'd0;
            snap_ts_q <= 32'd0;
            cycles_q  <= 32'd0;
            base_ts_q <= {(NUM_CH*32){1'b0}};
        end else begin
            cyc_q     <= cyc_q + 32'd1;
            snap_ts_q <= snap_ts_d;
            cycles_q  <= cycles_d;
            base_ts_q <= base_ts_d;
        end
    end

    assign out_cycles = cycles_q;
`endif

    assign out_valid = (state_q == S_DRAIN);
    assign out_last  = (state_q == S_DRAIN) && (ch_q == LAST_CH);
    assign out_ch    = ch_q;
    assign out_delta = delta_q;
    assign out_seq   = seq_q;
    assign busy      = (state_q != S_IDLE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_counter_rate_sequencer.sv
// Directed/randomized bench for counter_rate_sequencer; counters are synthetic linear ramps
// so every expected delta is plain arithmetic on the snapshot cycle numbers.
module tb_counter_rate_sequencer;

    localparam int N = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            enable;
    logic [31:0]     gate_cycles;
    logic [N*32-1:0] cnt_in;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      out_ch;
    logic [31:0]     out_delta;
    logic [15:0]     out_seq;
    logic            out_last;
    logic            busy;
    logic            overrun;
`ifdef COUNTER_RATE_SEQUENCER_WINDOW_LEN_EN
    logic [31:0]     out_cycles;
`endif

    int          n_cmp = 0;
    int          n_fail = 0;
    int          edge_n;
    int          t0;
    logic [31:0] cfg_init [N];
    int          cfg_num [N];
    int          cfg_den [N];

    counter_rate_sequencer #(.NUM_CH(N), .SZ_WIDTH(32), .CH_W(4), .SEQ_W(16)) dut (
        .clk(clk), .rst(rst), .enable(enable), .gate_cycles(gate_cycles), .cnt_in(cnt_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_ch(out_ch), .out_delta(out_delta),
        .out_seq(out_seq), .out_last(out_last),
`ifdef COUNTER_RATE_SEQUENCER_WINDOW_LEN_EN
        .out_cycles(out_cycles),
`endif
        .busy(busy), .overrun(overrun)
    );

    always #5 clk = ~clk;

    // Counter value driven during cycle t: init + floor((t - t0) * num / den), mod 2^32
    function automatic logic [31:0] cnt_model(input int k, input int t);
        longint span;
        span = longint'(t - t0);
        return cfg_init[k] + 32'((span * longint'(cfg_num[k])) / longint'(cfg_den[k]));
    endfunction

    // The DUT samples at edge e the value driven after edge e-1
    function automatic logic [31:0] exp_delta(input int k, input int snap_e, input int base_e);
        return cnt_model(k, snap_e - 1) - cnt_model(k, base_e - 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_cnt(input int t);
        for (int k = 0; k < N; k++) cnt_in[k*32 +: 32] = cnt_model(k, t);
    endtask

    // Counter stimulus: edge counter and ramp values updated just after every rising edge
    initial begin
        edge_n = 0;
        t0 = 0;
        for (int k = 0; k < N; k++) begin
            cfg_init[k] = 32'd0;
            cfg_num[k]  = 0;
            cfg_den[k]  = 1;
        end
        drive_cnt(0);
        forever begin
            @(posedge clk);
            edge_n = edge_n + 1;
            #1;
            drive_cnt(edge_n);
        end
    end

    task automatic apply_cfg();
        t0 = edge_n + 1;
        repeat (2) @(negedge clk);
    endtask

    task automatic check_quiet(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_busy"}, 32'(busy), 32'd0);
        chk({tag, "_overrun"}, 32'(overrun), 32'd0);
        chk({tag, "_seq"}, 32'(out_seq), 32'd0);
        chk({tag, "_ch"}, 32'(out_ch), 32'd0);
        chk({tag, "_delta"}, out_delta, 32'd0);
        chk({tag, "_last"}, 32'(out_last), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        enable = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        check_quiet(tag);
        rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic start(output int e0);
        enable = 1'b1;
        e0 = edge_n + 1;
        @(negedge clk);
        chk("prime_busy", 32'(busy), 32'd1);
        chk("prime_valid", 32'(out_valid), 32'd0);
    endtask

    // Wait for a window's beats and check nch of them; ch0 is held off for 'pre' cycles first
    task automatic drain(input int snap_e, input int base_e, input int seq, input int pre,
                         input int nch, input bit rnd);
        int guard;
        guard = 0;
        while (out_valid !== 1'b1 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        chk("valid_seen", 32'(out_valid), 32'd1);
        chk("first_beat_edge", 32'(edge_n), 32'(snap_e));
        for (int c = 0; c < nch; c++) begin
            int  st;
            int  lim;
            bit  acc;
            bit  r;
            st  = 0;
            acc = 1'b0;
            lim = (c == 0) ? pre : 0;
            while (!acc) begin
                if (st < lim) r = 1'b0;
                else if (rnd && st < lim + 3) r = 1'($urandom_range(0, 1));
                else r = 1'b1;
                out_ready = r;
                chk($sformatf("valid_ch%0d", c), 32'(out_valid), 32'd1);
                chk($sformatf("ch_ch%0d", c), 32'(out_ch), 32'(c));
                chk($sformatf("delta_ch%0d_seq%0d", c, seq), out_delta, exp_delta(c, snap_e, base_e));
                chk($sformatf("seq_ch%0d", c), 32'(out_seq), 32'(seq));
                chk($sformatf("last_ch%0d", c), 32'(out_last), 32'(c == N - 1));
`ifdef COUNTER_RATE_SEQUENCER_WINDOW_LEN_EN
                chk($sformatf("cycles_ch%0d", c), out_cycles, 32'(snap_e - base_e));
`endif
                @(negedge clk);
                acc = r;
                st++;
            end
        end
        out_ready = 1'b1;
    endtask

    initial begin
        int e0;
        int g;
        int seen;
        rst = 1'b0;
        enable = 1'b0;
        out_ready = 1'b1;
        gate_cycles = 32'd100;
        repeat (3) @(negedge clk);
        check_quiet("reset");
        rst = 1'b1;
        @(negedge clk);

        // Nominal: rates 1,3,0,0 over 100-cycle windows
        cfg_init[0] = $urandom; cfg_num[0] = 1; cfg_den[0] = 1;
        cfg_init[1] = $urandom; cfg_num[1] = 3; cfg_den[1] = 1;
        cfg_init[2] = $urandom; cfg_num[2] = 0; cfg_den[2] = 1;
        cfg_init[3] = $urandom; cfg_num[3] = 0; cfg_den[3] = 1;
        apply_cfg();
        gate_cycles = 32'd100;
        start(e0);
        for (int w = 1; w <= 3; w++) drain(e0 + 100*w, e0 + 100*(w-1), w - 1, 0, N, 1'b0);
        chk("nominal_overrun", 32'(overrun), 32'd0);

        // Wrap: ch2 starts just below 2^32 and ticks every other cycle
        do_reset("reset_wrap");
        cfg_init[2] = 32'hFFFF_FFF0; cfg_num[2] = 1; cfg_den[2] = 2;
        cfg_num[0] = int'($urandom_range(0, 50));
        apply_cfg();
        gate_cycles = 32'd64;
        start(e0);
        for (int w = 1; w <= 2; w++) drain(e0 + 64*w, e0 + 64*(w-1), w - 1, 0, N, 1'b0);
        chk("wrap_ch2_const", exp_delta(2, e0 + 64, e0), 32'h20);

        // Backpressure overrun: first beat stalled 150 cycles, next window spans two gates
        do_reset("reset_ovr");
        cfg_num[0] = 1; cfg_num[1] = int'($urandom_range(1, 9)); cfg_den[2] = 1;
        apply_cfg();
        gate_cycles = 32'd100;
        start(e0);
        drain(e0 + 100, e0, 0, 150, N, 1'b0);
        chk("ovr_sticky", 32'(overrun), 32'd1);
        drain(e0 + 300, e0 + 100, 1, 0, N, 1'b0);
        chk("ovr_ch0_span", exp_delta(0, e0 + 300, e0 + 100), 32'd200);
        chk("ovr_still_set", 32'(overrun), 32'd1);

        // Clamp: gate of 2 becomes a 5-cycle window, full-rate drain never overruns
        do_reset("reset_clamp");
        gate_cycles = 32'd2;
        start(e0);
        for (int w = 1; w <= 50; w++) drain(e0 + 5*w, e0 + 5*(w-1), w - 1, 0, N, 1'b0);
        chk("clamp_overrun", 32'(overrun), 32'd0);

        // Random rates, random gate and random bounded backpressure
        do_reset("reset_rand");
        for (int k = 0; k < N; k++) begin
            cfg_init[k] = $urandom;
            cfg_num[k]  = int'($urandom_range(0, 1000));
            cfg_den[k]  = int'($urandom_range(1, 3));
        end
        apply_cfg();
        g = int'($urandom_range(17, 60));
        gate_cycles = 32'(g);
        start(e0);
        for (int w = 1; w <= 8; w++) drain(e0 + g*w, e0 + g*(w-1), w - 1, 0, N, 1'b1);
        chk("rand_overrun", 32'(overrun), 32'd0);

        // Reset while the ch1 beat of the second window is valid
        do_reset("reset_rmd");
        gate_cycles = 32'd40;
        start(e0);
        drain(e0 + 40, e0, 0, 0, N, 1'b0);
        drain(e0 + 80, e0 + 40, 1, 0, 1, 1'b0);
        chk("rmd_ch1", 32'(out_ch), 32'd1);
        out_ready = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("rmd_valid", 32'(out_valid), 32'd0);
        chk("rmd_seq", 32'(out_seq), 32'd0);
        chk("rmd_overrun", 32'(overrun), 32'd0);
        chk("rmd_busy", 32'(busy), 32'd0);
        rst = 1'b1;
        e0 = edge_n + 1;
        @(negedge clk);
        chk("rmd_rebusy", 32'(busy), 32'd1);
        drain(e0 + 40, e0, 0, 0, N, 1'b0);

        // Disable during a stalled ch1 beat: beat holds, then sequencer idles without ch2/ch3
        do_reset("reset_dis");
        gate_cycles = 32'd40;
        start(e0);
        drain(e0 + 40, e0, 0, 0, N, 1'b0);
        drain(e0 + 80, e0 + 40, 1, 0, 1, 1'b0);
        out_ready = 1'b0;
        enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("dis_hold_valid", 32'(out_valid), 32'd1);
            chk("dis_hold_ch", 32'(out_ch), 32'd1);
            chk("dis_hold_delta", out_delta, exp_delta(1, e0 + 80, e0 + 40));
            chk("dis_hold_busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        chk("dis_valid", 32'(out_valid), 32'd0);
        chk("dis_busy", 32'(busy), 32'd0);
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (out_valid === 1'b1) seen++;
            @(negedge clk);
        end
        chk("dis_no_more_beats", 32'(seen), 32'd0);
        chk("dis_seq", 32'(out_seq), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
